// File: rtl/hotselect_sequencer.sv
// Sequencer that turns an accepted opcode into a one-hot mux select, waits for the selected
// path to settle, captures the mux output and offers it downstream over valid/ready.
module hotselect_sequencer #(
  parameter int                 WIDTH       = 32,
  parameter int                 SEL_W       = 16,
  parameter int                 OPC_W       = 4,
  parameter int                 SETTLE      = 2,
  parameter logic [SEL_W-1:0]   ENABLE_MASK = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [WIDTH-1:0]  mux_data,
  output logic [SEL_W-1:0]  hotselect,
  output logic [WIDTH-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              err
);

  localparam logic [1:0] S_IDLE        = 2'd0;
  localparam logic [1:0] S_SETTLE_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD        = 2'd2;

  // SETTLE is at most 15, so a 4-bit down-counter always suffices.
  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  logic [1:0] state;
  logic [3:0] cnt;

  assign op_ready = (state == S_IDLE);

  // NOTE: every register here uses non-blocking assignments so all state advances together
  // on the edge; the async reset clears every control and data register, so an aborted
  // operation never leaves a stale result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      hotselect    <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            if (ENABLE_MASK[opcode]) begin
              hotselect <= SEL_W'(1) << opcode;
              cnt       <= CNT_INIT;
              err       <= 1'b0;
              state     <= S_SETTLE_WAIT;
            end else begin
              // Masked opcode: report the error immediately without driving the mux.
              result       <= '0;
              err          <= 1'b1;
              result_valid <= 1'b1;
              state        <= S_HOLD;
            end
          end
        end
        S_SETTLE_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            result       <= mux_data;
            result_valid <= 1'b1;
            state        <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            hotselect    <= '0;
            state        <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hotselect_sequencer.sv
// Bench for hotselect_sequencer: a transaction-level model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_hotselect_sequencer;

  localparam int               WIDTH  = 32;
  localparam int               SEL_W  = 16;
  localparam int               OPC_W  = 4;
  localparam int               SETTLE = 2;
  localparam logic [SEL_W-1:0] MASK   = 16'h7FFF;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              op_valid = 1'b1;
  logic              op_ready;
  logic [OPC_W-1:0]  opcode = 4'd3;
  logic [WIDTH-1:0]  mux_data;
  logic [SEL_W-1:0]  hotselect;
  logic [WIDTH-1:0]  result;
  logic              result_valid;
  logic              result_ready = 1'b1;
  logic              err;

  logic [WIDTH-1:0]  tbl [SEL_W];

  int total = 0;
  int bad   = 0;

  hotselect_sequencer #(
    .WIDTH(WIDTH), .SEL_W(SEL_W), .OPC_W(OPC_W), .SETTLE(SETTLE), .ENABLE_MASK(MASK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode),
    .mux_data(mux_data), .hotselect(hotselect), .result(result),
    .result_valid(result_valid), .result_ready(result_ready), .err(err)
  );

  always #5 clk = ~clk;

  // One-hot multiplexer in front of the sequencer: OR of every selected table entry.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < SEL_W; i++)
      if (hotselect[i]) mux_data = mux_data | tbl[i];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one operation in flight, described by its age since acceptance.
  logic             m_active = 1'b0;
  logic             m_legal  = 1'b0;
  logic [OPC_W-1:0] m_op     = '0;
  int               m_age    = 0;
  logic             m_rv     = 1'b0;
  logic             m_err    = 1'b0;
  logic [WIDTH-1:0] m_result = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_rv     <= 1'b0;
      m_err    <= 1'b0;
      m_result <= '0;
      m_age    <= 0;
    end else if (!m_active) begin
      if (op_valid) begin
        m_active <= 1'b1;
        m_op     <= opcode;
        m_legal  <= MASK[opcode];
        m_age    <= 0;
        m_err    <= !MASK[opcode];
        m_rv     <= !MASK[opcode];
        if (!MASK[opcode]) m_result <= '0;
      end
    end else if (m_rv && result_ready) begin
      m_active <= 1'b0;
      m_rv     <= 1'b0;
    end else begin
      m_age <= m_age + 1;
      if (m_legal && (m_age + 1 == SETTLE)) begin
        m_rv     <= 1'b1;
        m_result <= tbl[m_op];
      end
    end
  end

  always @(negedge clk) begin
    check("op_ready", 64'(op_ready), 64'(!m_active));
    check("hotselect", 64'(hotselect), (m_active && m_legal) ? (64'd1 << m_op) : 64'd0);
    check("result_valid", 64'(result_valid), 64'(m_rv));
    check("err", 64'(err), 64'(m_err));
    check("result", 64'(result), 64'(m_result));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one opcode from IDLE; returns #1 after the accepting edge.
  task automatic do_op(input logic [OPC_W-1:0] op);
    op_valid = 1'b1;
    opcode   = op;
    step();
    op_valid = 1'b0;
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < SEL_W; i++) tbl[i] = 32'h1111_1111 * (i + 1);
    tbl[3] = 32'hDEADBEEF;

    // Reset with op_valid asserted.
    repeat (3) step();
    check("rst_hotselect", 64'(hotselect), 64'd0);
    check("rst_result_valid", 64'(result_valid), 64'd0);
    rst_n    = 1'b1;
    op_valid = 1'b0;
    check("rst_op_ready", 64'(op_ready), 64'd1);
    step();

    // Legal opcode 3, latency pinned by literals.
    do_op(4'd3);
    check("t2_hs_k", 64'(hotselect), 64'h0008);
    check("t2_rv_k", 64'(result_valid), 64'd0);
    step();
    check("t2_hs_k1", 64'(hotselect), 64'h0008);
    check("t2_rv_k1", 64'(result_valid), 64'd0);
    step();
    check("t2_rv_k2", 64'(result_valid), 64'd1);
    check("t2_result", 64'(result), 64'hDEADBEEF);
    check("t2_err", 64'(err), 64'd0);
    check("t2_hs_k2", 64'(hotselect), 64'h0008);
    step();
    check("t2_drained", 64'(result_valid), 64'd0);
    check("t2_hs_idle", 64'(hotselect), 64'd0);

    // Masked opcode 15.
    do_op(4'd15);
    check("t3_hs", 64'(hotselect), 64'd0);
    check("t3_rv", 64'(result_valid), 64'd1);
    check("t3_err", 64'(err), 64'd1);
    check("t3_result", 64'(result), 64'd0);
    step();

    // Backpressure: second offer while busy must be ignored.
    result_ready = 1'b0;
    do_op(4'd5);
    op_valid = 1'b1;
    opcode   = 4'd7;
    repeat (10) step();
    check("t4_result", 64'(result), 64'h6666_6666);
    check("t4_hs", 64'(hotselect), 64'h0020);
    check("t4_op_ready", 64'(op_ready), 64'd0);
    op_valid     = 1'b0;
    result_ready = 1'b1;
    step();
    check("t4_op_ready_after", 64'(op_ready), 64'd1);
    check("t4_rv_after", 64'(result_valid), 64'd0);

    // Back-to-back sweep of every opcode.
    for (int op = 0; op < SEL_W; op++) begin
      do_op(OPC_W'(op));
      cyc = 1;
      while (!op_ready && cyc < 50) begin
        step();
        cyc++;
      end
      check($sformatf("t5_period_%0d", op), 64'(cyc), MASK[op] ? 64'(SETTLE + 2) : 64'd2);
    end

    // Reset pulse during the settle wait.
    do_op(4'd9);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("t6_hs", 64'(hotselect), 64'd0);
    check("t6_rv", 64'(result_valid), 64'd0);
    check("t6_op_ready", 64'(op_ready), 64'd1);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();
    check("t6_no_result", 64'(result_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
